// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and processor reset sequencer: pulses PLL areset, waits for a stable
// synchronized lock, releases sys_reset_n, and retries a bounded number of times before faulting.
module pll_reset_sequencer #(
    parameter int unsigned ARESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned TW            = 17
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_areset,
    output logic       sys_reset_n,
    output logic       fault,
    output logic       lock_lost,
    output logic [2:0] state_o,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        StAreset   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    localparam logic [TW-1:0] AresetLast  = TW'(ARESET_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] StableLast  = TW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    MaxRetries  = 4'(MAX_RETRIES);

    logic [1:0]    rst_sync_q;
    logic          rst;
    logic          lock_meta_q;
    logic          lock_s_q;
    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    retry_q;
    logic [3:0]    retry_inc;
    logic          areset_q;
    logic          sys_reset_n_q;
    logic          fault_q;
    logic          lock_lost_q;

    // Reset asserts immediately but is released only on a clk_clk edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    always_ff @(posedge clk_clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    always_ff @(posedge clk_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StAreset;
            timer_q       <= '0;
            retry_q       <= '0;
            areset_q      <= 1'b1;
            sys_reset_n_q <= 1'b0;
            fault_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            lock_lost_q <= 1'b0;
            if (restart_req) begin
                state_q       <= StAreset;
                timer_q       <= '0;
                retry_q       <= '0;
                areset_q      <= 1'b1;
                sys_reset_n_q <= 1'b0;
                fault_q       <= 1'b0;
            end else begin
                case (state_q)
                    StAreset: begin
                        if (timer_q == AresetLast) begin
                            state_q  <= StWaitLock;
                            timer_q  <= '0;
                            areset_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    StWaitLock: begin
                        if (lock_s_q) begin
                            state_q <= StStable;
                            timer_q <= '0;
                        end else if (timer_q == TimeoutLast) begin
                            timer_q  <= '0;
                            retry_q  <= retry_inc;
                            areset_q <= 1'b1;
                            if (retry_inc == MaxRetries) begin
                                state_q <= StFault;
                                fault_q <= 1'b1;
                            end else begin
                                state_q <= StAreset;
                            end
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    StStable: begin
                        // A dropout only restarts the lock wait; it is not a failed attempt.
                        if (!lock_s_q) begin
                            state_q <= StWaitLock;
                            timer_q <= '0;
                        end else if (timer_q == StableLast) begin
                            state_q       <= StRun;
                            timer_q       <= '0;
                            retry_q       <= '0;
                            sys_reset_n_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    StRun: begin
                        if (!lock_s_q) begin
                            state_q       <= StAreset;
                            timer_q       <= '0;
                            areset_q      <= 1'b1;
                            sys_reset_n_q <= 1'b0;
                            lock_lost_q   <= 1'b1;
                        end
                    end
                    StFault: begin
                        areset_q      <= 1'b1;
                        sys_reset_n_q <= 1'b0;
                        fault_q       <= 1'b1;
                    end
                    default: begin
                        state_q       <= StAreset;
                        timer_q       <= '0;
                        areset_q      <= 1'b1;
                        sys_reset_n_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_areset  = areset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign fault       = fault_q;
    assign lock_lost   = lock_lost_q;
    assign state_o     = state_q;
    assign retry_count = retry_q;

endmodule
